// File: rtl/vga_640x480.sv
// ---------------------------------------------------------------------------
// vga_640x480 : 640x480 @ 60 Hz VGA timing generator.
//
// A 2-bit free-running divider turns the 100 MHz clk into a 25 MHz pixel
// tick (one tick every 4 clk). On each tick the horizontal counter hc
// advances; at the end of a line it wraps and the vertical counter vc
// advances. Sync and visible-area flags are decoded combinationally from the
// registered counters, so they carry no extra latency.
//
// Ports:
//   clk         in   100 MHz system clock
//   clr         in   synchronous, active-high reset
//   hsync       out  horizontal sync, active-low (low while hc < HSP)
//   vsync       out  vertical sync, active-low (low while vc < VSP)
//   hc [10:0]   out  horizontal pixel counter, 0 .. HPIXELS-1
//   vc [10:0]   out  vertical line counter, 0 .. VLINES-1
//   vidon       out  1 inside [HBP,HFP) x [VBP,VFP); gates the colour path
//   frame_start out  one-clk registered pulse after the frame wrap
//   frame_cnt   out  8-bit frame counter (only with VGA_FRAMECNT_EN)
//
// Configuration macro:
//   VGA_FRAMECNT_EN  adds the frame_cnt port and its register. Without it the
//                    port and register are absent and all else is identical.
// ---------------------------------------------------------------------------
module vga_640x480 #(
    parameter int HPIXELS = 800,
    parameter int VLINES  = 521,
    parameter int HSP     = 128,
    parameter int HBP     = 144,
    parameter int HFP     = 784,
    parameter int VSP     = 2,
    parameter int VBP     = 31,
    parameter int VFP     = 511
) (
    input  logic        clk,
    input  logic        clr,
    output logic        hsync,
    output logic        vsync,
    output logic [10:0] hc,
    output logic [10:0] vc,
    output logic        vidon,
    output logic        frame_start
`ifdef VGA_FRAMECNT_EN
    ,
    output logic [7:0]  frame_cnt
`endif
);

    localparam logic [10:0] H_LAST = 11'(HPIXELS - 1);
    localparam logic [10:0] V_LAST = 11'(VLINES - 1);
    localparam logic [10:0] H_SP   = 11'(HSP);
    localparam logic [10:0] H_BP   = 11'(HBP);
    localparam logic [10:0] H_FP   = 11'(HFP);
    localparam logic [10:0] V_SP   = 11'(VSP);
    localparam logic [10:0] V_BP   = 11'(VBP);
    localparam logic [10:0] V_FP   = 11'(VFP);

    logic [1:0]  div_q, div_d;
    logic [10:0] hc_q, hc_d;
    logic [10:0] vc_q, vc_d;
    logic        frame_start_q, frame_start_d;
    logic        tick;
    logic        h_wrap;
    logic        v_wrap;

    // Next-state logic for the divider and the two counters.
    // NOTE: every signal written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        tick          = (div_q == 2'd3);
        // ">=" rather than "==" so an out-of-range count also wraps.
        h_wrap        = (hc_q >= H_LAST);
        v_wrap        = (vc_q >= V_LAST);
        div_d         = div_q + 2'd1;
        hc_d          = hc_q;
        vc_d          = vc_q;
        frame_start_d = 1'b0;

        if (tick) begin
            if (h_wrap) begin
                hc_d = '0;
                if (v_wrap) begin
                    vc_d          = '0;
                    frame_start_d = 1'b1;
                end else begin
                    vc_d = vc_q + 11'd1;
                end
            end else begin
                hc_d = hc_q + 11'd1;
                // A line count already past the frame end is pulled back at
                // once instead of waiting for the end of the line.
                if (vc_q > V_LAST) begin
                    vc_d = '0;
                end
            end
        end
    end

    // NOTE: clr is sampled on the clock edge and overrides tick and wrap;
    // non-blocking assignments keep every flop updating from pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            div_q         <= '0;
            hc_q          <= '0;
            vc_q          <= '0;
            frame_start_q <= 1'b0;
        end else begin
            div_q         <= div_d;
            hc_q          <= hc_d;
            vc_q          <= vc_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAMECNT_EN
    logic [7:0] frame_cnt_q, frame_cnt_d;

    // Counts during the clk in which frame_start is high; wraps modulo 256.
    always_comb begin
        frame_cnt_d = frame_cnt_q + {7'd0, frame_start_q};
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    // Decoded straight from the registered counters: zero added latency.
    assign hc          = hc_q;
    assign vc          = vc_q;
    assign hsync       = (hc_q >= H_SP);
    assign vsync       = (vc_q >= V_SP);
    assign vidon       = (hc_q >= H_BP) && (hc_q < H_FP) &&
                         (vc_q >= V_BP) && (vc_q < V_FP);
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_640x480.sv
// ---------------------------------------------------------------------------
// tb_vga_640x480 : self-checking bench for vga_640x480.
//
// Two instances share clk and clr: one with the default 640x480 timing and a
// small-geometry one so whole frames fit in a short run. A reference model
// derives every expected output from the number of clk edges since reset
// (ticks = edges/4, position = ticks mod frame size).
// ---------------------------------------------------------------------------
module tb_vga_640x480;

    // Small geometry: 16 x 8 positions per frame, 512 clk per frame.
    localparam int SH   = 16;
    localparam int SV   = 8;
    localparam int SHSP = 3;
    localparam int SHBP = 4;
    localparam int SHFP = 13;
    localparam int SVSP = 2;
    localparam int SVBP = 2;
    localparam int SVFP = 6;

    logic        clk;
    logic        clr;
    logic        d_hsync, d_vsync, d_vidon, d_fs;
    logic [10:0] d_hc, d_vc;
    logic        s_hsync, s_vsync, s_vidon, s_fs;
    logic [10:0] s_hc, s_vc;
`ifdef VGA_FRAMECNT_EN
    logic [7:0]  d_fcnt, s_fcnt;
`endif

    vga_640x480 u_def (
        .clk         (clk),
        .clr         (clr),
        .hsync       (d_hsync),
        .vsync       (d_vsync),
        .hc          (d_hc),
        .vc          (d_vc),
        .vidon       (d_vidon),
        .frame_start (d_fs)
`ifdef VGA_FRAMECNT_EN
        ,
        .frame_cnt   (d_fcnt)
`endif
    );

    vga_640x480 #(
        .HPIXELS (SH),
        .VLINES  (SV),
        .HSP     (SHSP),
        .HBP     (SHBP),
        .HFP     (SHFP),
        .VSP     (SVSP),
        .VBP     (SVBP),
        .VFP     (SVFP)
    ) u_small (
        .clk         (clk),
        .clr         (clr),
        .hsync       (s_hsync),
        .vsync       (s_vsync),
        .hc          (s_hc),
        .vc          (s_vc),
        .vidon       (s_vidon),
        .frame_start (s_fs)
`ifdef VGA_FRAMECNT_EN
        ,
        .frame_cnt   (s_fcnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;
    int k        = 0;   // clk edges since the last edge that saw clr high

    always @(posedge clk) begin
        if (clr) k <= 0;
        else     k <= k + 1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (k=%0d, t=%0t)", name, act, exp, k, $time);
        end
    endtask

    typedef struct {
        int hc;
        int vc;
        bit hs;
        bit vs;
        bit vid;
        bit fs;
        int fcnt;
    } exp_t;

    // Expected outputs after k edges out of reset, from plain arithmetic.
    function automatic exp_t model(input int kk, input int h, input int v,
                                   input int hsp, input int hbp, input int hfp,
                                   input int vsp, input int vbp, input int vfp);
        exp_t e;
        int   t;
        int   pos;
        t      = kk / 4;
        pos    = t % (h * v);
        e.hc   = pos % h;
        e.vc   = pos / h;
        e.hs   = (e.hc >= hsp);
        e.vs   = (e.vc >= vsp);
        e.vid  = (e.hc >= hbp) && (e.hc < hfp) && (e.vc >= vbp) && (e.vc < vfp);
        e.fs   = (kk > 0) && (kk % 4 == 0) && (pos == 0);
        e.fcnt = (kk >= 1) ? (((kk - 1) / (4 * h * v)) % 256) : 0;
        return e;
    endfunction

    // Continuous comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            exp_t ed;
            exp_t es;
            ed = model(k, 800, 521, 128, 144, 784, 2, 31, 511);
            es = model(k, SH, SV, SHSP, SHBP, SHFP, SVSP, SVBP, SVFP);
            check("def_hc",    int'(d_hc),    ed.hc);
            check("def_vc",    int'(d_vc),    ed.vc);
            check("def_hsync", int'(d_hsync), int'(ed.hs));
            check("def_vsync", int'(d_vsync), int'(ed.vs));
            check("def_vidon", int'(d_vidon), int'(ed.vid));
            check("def_fs",    int'(d_fs),    int'(ed.fs));
            check("sm_hc",     int'(s_hc),    es.hc);
            check("sm_vc",     int'(s_vc),    es.vc);
            check("sm_hsync",  int'(s_hsync), int'(es.hs));
            check("sm_vsync",  int'(s_vsync), int'(es.vs));
            check("sm_vidon",  int'(s_vidon), int'(es.vid));
            check("sm_fs",     int'(s_fs),    int'(es.fs));
`ifdef VGA_FRAMECNT_EN
            check("def_fcnt",  int'(d_fcnt),  ed.fcnt);
            check("sm_fcnt",   int'(s_fcnt),  es.fcnt);
`endif
        end
    end

    // Hold clr for n edges; returns at the negedge just after release (k==0).
    task automatic do_reset(input int n);
        @(negedge clk);
        clr = 1'b1;
        repeat (n) @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic run_to(input int target);
        while (k < target) @(negedge clk);
    endtask

    typedef struct {
        int k;
        int hc;
        int vc;
        bit hs;
        bit vs;
        bit vid;
    } vec_t;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[12];
        int   cnt_a;
        int   cnt_b;
        int   cnt_c;
        int   cnt_d;
        int   fs_at;
        bit   found;

        // Hand-derived points on the default 800 x 521 timing.
        tbl[0]  = '{k: 0,    hc: 0,   vc: 0, hs: 0, vs: 0, vid: 0};
        tbl[1]  = '{k: 3,    hc: 0,   vc: 0, hs: 0, vs: 0, vid: 0};
        tbl[2]  = '{k: 4,    hc: 1,   vc: 0, hs: 0, vs: 0, vid: 0};
        tbl[3]  = '{k: 511,  hc: 127, vc: 0, hs: 0, vs: 0, vid: 0};
        tbl[4]  = '{k: 512,  hc: 128, vc: 0, hs: 1, vs: 0, vid: 0};
        tbl[5]  = '{k: 576,  hc: 144, vc: 0, hs: 1, vs: 0, vid: 0};
        tbl[6]  = '{k: 3196, hc: 799, vc: 0, hs: 1, vs: 0, vid: 0};
        tbl[7]  = '{k: 3199, hc: 799, vc: 0, hs: 1, vs: 0, vid: 0};
        tbl[8]  = '{k: 3200, hc: 0,   vc: 1, hs: 0, vs: 0, vid: 0};
        tbl[9]  = '{k: 3204, hc: 1,   vc: 1, hs: 0, vs: 0, vid: 0};
        tbl[10] = '{k: 6400, hc: 0,   vc: 2, hs: 0, vs: 1, vid: 0};
        tbl[11] = '{k: 7200, hc: 200, vc: 2, hs: 1, vs: 1, vid: 0};

        clr = 1'b1;
        repeat (2) @(negedge clk);

        // Reset: hold 3 clk; hc stays 0 for 3 clk, first tick on the 4th.
        do_reset(3);
        chk_en = 1'b1;
        check("rst_hc_k0",    int'(d_hc), 0);
        check("rst_vc_k0",    int'(d_vc), 0);
        check("rst_hsync_k0", int'(d_hsync), 0);
        check("rst_vsync_k0", int'(d_vsync), 0);
        check("rst_vidon_k0", int'(d_vidon), 0);
        check("rst_fs_k0",    int'(d_fs), 0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("rst_hc_hold", int'(d_hc), 0);
        end
        @(negedge clk);
        check("rst_hc_first_tick", int'(d_hc), 1);
        check("rst_hsync_first_tick", int'(d_hsync), 0);
        check("rst_vidon_first_tick", int'(d_vidon), 0);

        // Table-driven points on the default timing.
        do_reset(2);
        for (int i = 0; i < 12; i++) begin
            run_to(tbl[i].k);
            check($sformatf("tbl%0d_hc", i),    int'(d_hc),    tbl[i].hc);
            check($sformatf("tbl%0d_vc", i),    int'(d_vc),    tbl[i].vc);
            check($sformatf("tbl%0d_hsync", i), int'(d_hsync), int'(tbl[i].hs));
            check($sformatf("tbl%0d_vsync", i), int'(d_vsync), int'(tbl[i].vs));
            check($sformatf("tbl%0d_vidon", i), int'(d_vidon), int'(tbl[i].vid));
        end

        // One default line: hsync is low for 128 pixels = 512 clk.
        do_reset(1);
        cnt_a = 0;
        for (int i = 0; i < 3200; i++) begin
            if (!d_hsync) cnt_a++;
            @(negedge clk);
        end
        check("line_hsync_low_clk", cnt_a, 512);
        check("line_wrap_hc", int'(d_hc), 0);
        check("line_wrap_vc", int'(d_vc), 1);

        // One small frame plus a few clk, k = 0 .. 515.
        do_reset(1);
        cnt_a = 0; cnt_b = 0; cnt_c = 0; cnt_d = 0; fs_at = -1;
        for (int i = 0; i < 516; i++) begin
            if (i < 512 && s_vidon) cnt_a++;
            if (i < 512 && !s_vsync) cnt_b++;
            if (s_fs) begin
                cnt_c++;
                fs_at = i;
            end
            // Line vc == VFP spans ticks 96..111, i.e. k 384..447.
            if (i >= 384 && i < 448 && s_vidon) cnt_d++;
            // vc == VBP line: hc 3 -> 4 and 12 -> 13 are the vidon edges.
            if (i == 140) check("win_before_hbp", int'(s_vidon), 0);
            if (i == 144) check("win_at_hbp",     int'(s_vidon), 1);
            if (i == 176) check("win_last_vis",   int'(s_vidon), 1);
            if (i == 180) check("win_at_hfp",     int'(s_vidon), 0);
            @(negedge clk);
        end
        check("frame_vidon_clk",    cnt_a, (SHFP - SHBP) * (SVFP - SVBP) * 4);
        check("frame_vsync_low",    cnt_b, SVSP * SH * 4);
        check("frame_fs_pulses",    cnt_c, 1);
        check("frame_fs_position",  fs_at, 4 * SH * SV);
        check("frame_vfp_line_vid", cnt_d, 0);

        // Mid-frame reset at hc == 10, vc == 5 on the small instance.
        found = 1'b0;
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (s_hc == 11'd10 && s_vc == 11'd5) found = 1'b1;
        end
        check("mid_reached", int'(found), 1);
        clr = 1'b1;
        @(negedge clk);
        check("mid_hc", int'(s_hc), 0);
        check("mid_vc", int'(s_vc), 0);
        check("mid_fs", int'(s_fs), 0);
        @(negedge clk);
        clr = 1'b0;
        cnt_c = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (s_fs || d_fs) cnt_c++;
        end
        check("mid_no_spurious_fs", cnt_c, 0);

        // Randomized run lengths and reset pulses, checked by the model.
        for (int it = 0; it < 25; it++) begin
            int run_len;
            run_len = int'($urandom_range(50, 2000));
            repeat (run_len) @(negedge clk);
            if ($urandom_range(0, 3) != 0) begin
                clr = 1'b1;
                repeat (int'($urandom_range(1, 4))) @(negedge clk);
                clr = 1'b0;
            end
        end

        chk_en = 1'b0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
